// File: rtl/mac_accumulator.sv
// mac_accumulator
//   Accumulates a burst of unsigned products coming from an upstream
//   multiplier. It presents the sum, the product count and a sticky
//   overflow flag once the burst's last product has been captured.
//   The result is held until the consumer takes it.
//
// Parameters
//   LEN    operand width of the upstream multiplier (products are 2*LEN wide)
//   ACC_W  accumulator width, must be >= 2*LEN
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   product on in_data is valid
//   in_ready   block accepts a product this cycle
//   in_data    unsigned product (2*LEN bits)
//   in_last    final product of the burst (qualified by in_valid)
//   out_valid  accumulated result available
//   out_ready  consumer accepts the result
//   out_acc    accumulated sum (ACC_W bits)
//   out_cnt    number of products in the burst, saturating at 255
//   out_ovf    sticky overflow flag for the burst
//
// Configuration
//   MAC_SAT_EN  when defined, an overflowing addition clamps out_acc to
//               all ones and holds it there for the rest of the burst;
//               otherwise additions wrap. out_ovf is set in both builds.

module mac_accumulator #(
  parameter int LEN   = 8,
  parameter int ACC_W = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2*LEN-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_acc,
  output logic [7:0]       out_cnt,
  output logic             out_ovf
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic             started;
  logic [ACC_W-1:0] acc_next;
  logic [7:0]       cnt_next;
  logic             ovf_next;
  logic [ACC_W-1:0] data_ext;
  logic [ACC_W:0]   sum;
  logic             transfer;

  // started keeps in_ready low while reset is asserted and lets it rise
  // on the first clock edge after reset is released.
  assign in_ready  = started && (state != DONE);
  assign out_valid = (state == DONE);
  assign transfer  = in_valid && in_ready;

  assign data_ext = ACC_W'(in_data);
  // The extra top bit of sum is the carry out of the accumulator.
  assign sum      = {1'b0, out_acc} + {1'b0, data_ext};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      started <= 1'b0;
      out_acc <= '0;
      out_cnt <= '0;
      out_ovf <= 1'b0;
    end else begin
      state   <= state_next;
      started <= 1'b1;
      out_acc <= acc_next;
      out_cnt <= cnt_next;
      out_ovf <= ovf_next;
    end
  end

  always_comb begin
    state_next = state;
    acc_next   = out_acc;
    cnt_next   = out_cnt;
    ovf_next   = out_ovf;

    unique case (state)
      IDLE: begin
        if (transfer) begin
          acc_next   = data_ext;
          cnt_next   = 8'd1;
          ovf_next   = 1'b0;
          state_next = in_last ? DONE : ACC;
        end
      end

      ACC: begin
        if (transfer) begin
`ifdef MAC_SAT_EN
          // Once clamped, the sum stays at full scale for the rest of the burst.
          if (sum[ACC_W] || out_ovf) begin
            acc_next = '1;
          end else begin
            acc_next = sum[ACC_W-1:0];
          end
`else
          acc_next = sum[ACC_W-1:0];
`endif
          if (sum[ACC_W]) begin
            ovf_next = 1'b1;
          end
          if (out_cnt != 8'hFF) begin
            cnt_next = out_cnt + 8'd1;
          end
          if (in_last) begin
            state_next = DONE;
          end
        end
      end

      DONE: begin
        if (out_ready) begin
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: doc/mac_accumulator.md
MAC_ACCUMULATOR -- requirements
Module: mac_accumulator

Interface
REQ-001 Parameter LEN, default 8: operand width of the upstream multiplier; product width is 2*LEN.
REQ-002 Parameter ACC_W, default 24: accumulator width; legal only when ACC_W >= 2*LEN.
REQ-003 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 in_valid  input  1  product word on in_data is valid.
REQ-007 in_ready  output  1  block accepts a product this cycle.
REQ-008 in_data  input  2*LEN  unsigned product from the Dadda multiplier.
REQ-009 in_last  input  1  marks the final product of a burst; qualified by in_valid.
REQ-010 out_valid  output  1  accumulated result available.
REQ-011 out_ready  input  1  consumer accepts the result.
REQ-012 out_acc  output  ACC_W  accumulated sum.
REQ-013 out_cnt  output  8  number of products in the burst.
REQ-014 out_ovf  output  1  sticky overflow flag for the burst.

Function
REQ-015 Transfer SHALL occur only on a rising clk edge where in_valid and in_ready are both 1.
REQ-016 FSM states: IDLE, ACC, DONE.
REQ-017 in_ready SHALL be 1 in IDLE and ACC and 0 in DONE. out_valid SHALL be 1 only in DONE.
REQ-018 IDLE, on transfer: out_acc <= zero-extended in_data, out_cnt <= 1, out_ovf <= 0. Next state is DONE if in_last, else ACC.
REQ-019 ACC, on transfer: out_acc <= out_acc + zero-extended in_data, out_cnt <= out_cnt + 1. out_cnt saturates at 255. Next state is DONE if in_last.
REQ-020 Cycles with in_valid = 0 SHALL leave all state unchanged; gaps inside a burst are legal.
REQ-021 Latency: out_valid SHALL rise on the edge that captures the in_last transfer, i.e. visible the cycle after in_last is presented.
REQ-022 In DONE, out_acc, out_cnt and out_ovf SHALL be held stable, and in_valid/in_data SHALL be ignored.
REQ-023 DONE with out_ready = 1 SHALL move to IDLE; out_valid deasserts on that edge.
REQ-024 In IDLE, outputs SHALL keep the last result until the next burst's first transfer overwrites them.
REQ-025 Carry out of bit ACC_W-1 during an addition SHALL set out_ovf, which stays set until the next burst starts.

Reset
REQ-026 While rst_n = 0: state IDLE, out_acc = 0, out_cnt = 0, out_ovf = 0, out_valid = 0, in_ready = 0.
REQ-027 in_ready SHALL be 1 from the first clk edge after rst_n deasserts.
REQ-028 Reset mid-burst or in DONE SHALL discard all partial and pending results.

Configuration
REQ-029 Macro MAC_SAT_EN. When defined, an overflowing addition SHALL clamp out_acc to 2^ACC_W-1, set out_ovf, and hold the clamp for later additions in the burst.
REQ-030 When MAC_SAT_EN is undefined, additions SHALL wrap modulo 2^ACC_W and still set out_ovf.

Verification
REQ-031 Burst in_data = 0x0001, 0x0002, 0x0003, last on the third:
- one cycle later, out_valid = 1, out_acc = 0x000006, out_cnt = 3, out_ovf = 0.
REQ-032 Single transfer in_data = 0xFE01 with in_last = 1:
- out_acc = 0x00FE01, out_cnt = 1, out_valid the next cycle.
REQ-033 In DONE, hold out_ready = 0 for 5 cycles while driving in_valid = 1 with 0x1234:
- in_ready = 0 and outputs are unchanged throughout;
- after out_ready = 1, state is IDLE and 0x1234 is accepted as a fresh burst.
REQ-034 With ACC_W = 16, burst 0xFFFF then 0x0002 (last):
- without MAC_SAT_EN, out_acc = 0x0001 and out_ovf = 1;
- with MAC_SAT_EN, out_acc = 0xFFFF and out_ovf = 1.
REQ-035 Assert rst_n = 0 after 2 of 4 products:
- outputs are zero and out_valid = 0;
- a following burst 0x0005 (last) yields out_acc = 5, out_cnt = 1.
REQ-036 Burst 0x0010, gap of 3 idle cycles, then 0x0020 (last):
- out_acc = 0x000030, out_cnt = 2.
